// File: rtl/lane_pkg.sv
// Shared lane definitions: scheduler states, lane geometry defaults and the lane colour palette.
package lane_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDrain,
    StDone
  } sched_state_e;

  localparam int unsigned NumLanesDefault = 4;
  localparam int unsigned LaneDepth       = 96;

  // 12-bit RGB (4:4:4) colours for the VGA path
  localparam logic [11:0] ColourLane0 = 12'hF00;
  localparam logic [11:0] ColourLane1 = 12'h0F0;
  localparam logic [11:0] ColourLane2 = 12'h00F;
  localparam logic [11:0] ColourLane3 = 12'hFF0;

  function automatic logic [11:0] lane_colour(input int unsigned lane);
    logic [11:0] colour;
    case (lane % 4)
      0:       colour = ColourLane0;
      1:       colour = ColourLane1;
      2:       colour = ColourLane2;
      default: colour = ColourLane3;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Counts accepted frame ticks modulo BEAT_FRAMES; beat_strobe marks the first frame of a beat.
module beat_timer #(
  parameter int unsigned BEAT_FRAMES = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic beat_strobe
);

  localparam int unsigned    CntW   = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BEAT_FRAMES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign beat_strobe = (cnt_q == '0);

endmodule

// File: rtl/lane_scheduler.sv
// Walks the song pattern ROM one beat at a time and drives per-lane drop requests.
// Build option: SONG_LOOP_EN loops the song forever instead of draining to DONE.
module lane_scheduler
  import lane_pkg::*;
#(
  parameter int unsigned NUM_LANES    = NumLanesDefault,
  parameter int unsigned SONG_LEN     = 64,
  parameter int unsigned BEAT_FRAMES  = 12,
  parameter int unsigned DRAIN_FRAMES = LaneDepth,
  localparam int unsigned AddrW       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic                 pause,
  output logic [AddrW-1:0]     song_addr,
  input  logic [NUM_LANES-1:0] song_data,
  output logic [NUM_LANES-1:0] drop_block,
  output logic                 busy,
  output logic                 song_done
);

  localparam int unsigned      DrainW   = (DRAIN_FRAMES > 1) ? $clog2(DRAIN_FRAMES) : 1;
  localparam logic [AddrW-1:0]  LastPtr  = AddrW'(SONG_LEN - 1);
  localparam logic [DrainW-1:0] DrainMax = DrainW'(DRAIN_FRAMES - 1);

  sched_state_e         state_q;
  logic [AddrW-1:0]     ptr_q;
  logic [DrainW-1:0]    drain_q;
  logic [NUM_LANES-1:0] drop_q;

  logic tick_ok;
  logic launch;
  logic beat_strobe;

  assign tick_ok = frame_tick & ~pause;
  // start has priority over a coincident tick when (re)launching a song
  assign launch  = start & ((state_q == StIdle) | (state_q == StDone));

  beat_timer #(
    .BEAT_FRAMES(BEAT_FRAMES)
  ) u_beat_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (launch),
    .tick       (tick_ok && (state_q == StPlay)),
    .beat_strobe(beat_strobe)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      drain_q <= '0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StPlay;
            ptr_q   <= '0;
            drain_q <= '0;
          end
        end
        StPlay: begin
          if (tick_ok) begin
            if (beat_strobe) begin
              drop_q <= song_data;
              if (ptr_q == LastPtr) begin
                ptr_q <= '0;
`ifndef SONG_LOOP_EN
                state_q <= StDrain;
`endif
              end else begin
                ptr_q <= ptr_q + AddrW'(1);
              end
            end else begin
              drop_q <= '0;
            end
          end
        end
        StDrain: begin
          if (tick_ok) begin
            drop_q <= '0;
            if (drain_q == DrainMax) begin
              state_q <= StDone;
              drain_q <= '0;
            end else begin
              drain_q <= drain_q + DrainW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign song_addr  = ptr_q;
  assign drop_block = drop_q;
  assign busy       = (state_q == StPlay) || (state_q == StDrain);
  assign song_done  = (state_q == StDone);

endmodule
